// File: rtl/eth_csr_pkg.sv
// eth_csr_pkg: shared state encoding and command-field constants for the Ethernet CSR master.
package eth_csr_pkg;
  typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT, DONE} t_eth_csr_state;
  localparam int ETH_CSR_WR_BIT = 16;
  localparam int ETH_CSR_RD_BIT = 17;
  localparam logic [31:0] ETH_CSR_TIMEOUT_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/eth_csr_mm_master_if.sv
// eth_csr_mm_master_if: Avalon-MM bus between the CSR master and the MAC/PHY management port.
interface eth_csr_mm_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;
  modport master(output address, read, write, writedata, input readdata, readdatavalid, waitrequest);
  modport slave(input address, read, write, writedata, output readdata, readdatavalid, waitrequest);
endinterface

// File: rtl/eth_csr_timeout_cnt.sv
// eth_csr_timeout_cnt: counts enabled cycles since clear; expire flags cycle TIMEOUT_CYC-1.
module eth_csr_timeout_cnt #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic pck_cp2af_softReset_T1,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign expire = en && (cnt_q == W'(TIMEOUT_CYC - 1));
  always_comb cnt_d = clr ? '0 : (en && !expire) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge pck_cp2af_softReset_T1)
    if (pck_cp2af_softReset_T1) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/eth_csr_mm_master.sv
// eth_csr_mm_master: runs one Avalon-MM transaction per host command level, reports status.
// Build with ETH_CSR_TIMEOUT_EN to abort transactions stalled for TIMEOUT_CYC cycles.
module eth_csr_mm_master
  import eth_csr_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 pck_cp2af_softReset_T1,
  input  logic [31:0]          ctrl_addr,
  input  logic [DATA_W-1:0]    wr_data,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic                 err_illegal,
  output logic [15:0]          txn_cnt,
  eth_csr_mm_master_if.master  avm
);
  t_eth_csr_state    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rd_data_q, rd_data_d;
  logic              busy_q, busy_d, done_q, done_d, err_to_q, err_to_d, err_il_q, err_il_d;
  logic              avm_read_q, avm_read_d, avm_write_q, avm_write_d;
  logic [15:0]       txn_cnt_q, txn_cnt_d;
  logic [1:0]        cmd;
  logic              accept, expire, unused_ok;
  assign cmd       = {ctrl_addr[ETH_CSR_RD_BIT], ctrl_addr[ETH_CSR_WR_BIT]};
  assign accept    = (state_q == IDLE) && (cmd != 2'b00);
  assign unused_ok = ^{ctrl_addr[31:18], 1'(TIMEOUT_CYC)};
`ifdef ETH_CSR_TIMEOUT_EN
  eth_csr_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk(clk),
    .pck_cp2af_softReset_T1(pck_cp2af_softReset_T1),
    .clr(accept),
    .en(state_q inside {WR_REQ, RD_REQ, RD_WAIT}),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_data_d   = rd_data_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_to_d    = err_to_q;
    err_il_d    = err_il_q;
    avm_read_d  = avm_read_q;
    avm_write_d = avm_write_q;
    txn_cnt_d   = txn_cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        addr_d      = ctrl_addr[ADDR_W-1:0];
        wdata_d     = wr_data;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        err_to_d    = 1'b0;
        err_il_d    = (cmd == 2'b11);
        avm_write_d = (cmd == 2'b01);
        avm_read_d  = (cmd == 2'b10);
        state_d     = (cmd == 2'b11) ? DONE : (cmd == 2'b01) ? WR_REQ : RD_REQ;
      end
      WR_REQ: if (!avm.waitrequest || expire) begin
        avm_write_d = 1'b0;
        err_to_d    = avm.waitrequest;
        state_d     = DONE;
      end
      RD_REQ: if (!avm.waitrequest) begin
        avm_read_d = 1'b0;
        state_d    = RD_WAIT;
      end else if (expire) begin
        avm_read_d = 1'b0;
        err_to_d   = 1'b1;
        rd_data_d  = DATA_W'(ETH_CSR_TIMEOUT_DATA);
        state_d    = DONE;
      end
      RD_WAIT: if (avm.readdatavalid || expire) begin
        err_to_d  = !avm.readdatavalid;
        rd_data_d = avm.readdatavalid ? avm.readdata : DATA_W'(ETH_CSR_TIMEOUT_DATA);
        state_d   = DONE;
      end
      DONE: begin
        // done is always clear on entry, so !done_q marks the first DONE cycle
        if (!done_q) begin
          done_d    = 1'b1;
          busy_d    = 1'b0;
          txn_cnt_d = txn_cnt_q + 16'd1;
        end
        if (cmd == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge pck_cp2af_softReset_T1)
    if (pck_cp2af_softReset_T1) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_to_q    <= 1'b0;
      err_il_q    <= 1'b0;
      avm_read_q  <= 1'b0;
      avm_write_q <= 1'b0;
      txn_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_to_q    <= err_to_d;
      err_il_q    <= err_il_d;
      avm_read_q  <= avm_read_d;
      avm_write_q <= avm_write_d;
      txn_cnt_q   <= txn_cnt_d;
    end
  assign rd_data       = rd_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_timeout   = err_to_q;
  assign err_illegal   = err_il_q;
  assign txn_cnt       = txn_cnt_q;
  assign avm.address   = addr_q;
  assign avm.writedata = wdata_q;
  assign avm.read      = avm_read_q;
  assign avm.write     = avm_write_q;
endmodule

// File: tb/tb_eth_csr_mm_master.sv
// tb_eth_csr_mm_master: directed and randomized commands against a transaction-level model
// and a simple Avalon slave with configurable stalls and read latency.
module tb_eth_csr_mm_master;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ctrl_addr, wr_data, rd_data;
  logic        busy, done, err_timeout, err_illegal;
  logic [15:0] txn_cnt;
  eth_csr_mm_master_if #(.ADDR_W(16), .DATA_W(32)) avm();
  eth_csr_mm_master #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk),
    .pck_cp2af_softReset_T1(rst),
    .ctrl_addr(ctrl_addr),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .busy(busy),
    .done(done),
    .err_timeout(err_timeout),
    .err_illegal(err_illegal),
    .txn_cnt(txn_cnt),
    .avm(avm)
  );
  always #5 clk = ~clk;
  int n_tests = 0, n_fail = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [31:0] mem [logic [15:0]];
  int          n_wr = 0, n_rd = 0, rd_hi = 0, wr_hi = 0, lat = 0, stall_left = 0, pend_cnt = 0;
  bit          stuck = 0, rnd_stall = 0, pend = 0;
  logic [15:0] pend_addr, last_addr;
  logic [31:0] last_wdata;
  function automatic logic [31:0] bus_val(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : {a, ~a};
  endfunction
  initial begin
    avm.waitrequest   = 1'b0;
    avm.readdatavalid = 1'b0;
    avm.readdata      = '0;
    forever begin
      @(negedge clk);
      if (avm.read) rd_hi++;
      if (avm.write) wr_hi++;
      if (avm.write && !avm.waitrequest) begin
        mem[avm.address] = avm.writedata;
        n_wr++;
        last_addr  = avm.address;
        last_wdata = avm.writedata;
      end
      if (avm.read && !avm.waitrequest) begin
        n_rd++;
        pend      = 1;
        pend_addr = avm.address;
        pend_cnt  = lat;
      end
      @(posedge clk);
      #1;
      if (pend && pend_cnt == 0) begin
        avm.readdatavalid = 1'b1;
        avm.readdata      = bus_val(pend_addr);
        pend              = 0;
      end else begin
        avm.readdatavalid = 1'b0;
        avm.readdata      = $urandom;
        if (pend) pend_cnt--;
      end
      avm.waitrequest = stuck || stall_left > 0 || (rnd_stall && $urandom_range(0, 3) == 0);
      if (!stuck && stall_left > 0) stall_left--;
    end
  end
  logic [31:0] exp_mem [logic [15:0]];
  logic [15:0] exp_txn = '0;
  logic [31:0] exp_rd = '0;
  function automatic logic [31:0] exp_val(input logic [15:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : {a, ~a};
  endfunction
  task automatic run_cmd(input logic [31:0] ca, input logic [31:0] wd, input int stall, output int k);
    @(posedge clk);
    #2;
    ctrl_addr  = ca;
    wr_data    = wd;
    stall_left = stall;
    k = 0;
    for (int i = 1; i <= 200 && k == 0; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) check("busy_accept", {done, busy}, 2'b01);
      if (done) k = i;
    end
    if (k == 0) begin
      check("done_wait", done, 1);
      k = 201;
    end
  endtask
  task automatic do_txn(input logic [31:0] ca, input logic [31:0] wd, input int stall, input bit tmo,
                        output int k);
    logic [1:0]  c;
    logic [15:0] a;
    int          w0, r0;
    c  = ca[17:16];
    a  = ca[15:0];
    w0 = n_wr;
    r0 = n_rd;
    run_cmd(ca, wd, stall, k);
    exp_txn = exp_txn + 16'd1;
    if (c == 2'b01) exp_mem[a] = wd;
    if (c == 2'b10) exp_rd = tmo ? 32'hDEAD_BEEF : exp_val(a);
    check("busy_done", busy, 0);
    check("txn_cnt", txn_cnt, exp_txn);
    check("rd_data", rd_data, exp_rd);
    check("err_illegal", err_illegal, c == 2'b11);
    check("err_timeout", err_timeout, tmo);
    check("wr_cycles", n_wr - w0, c == 2'b01 && !tmo);
    check("rd_cycles", n_rd - r0, c == 2'b10 && !tmo);
    if (c == 2'b01) check("wr_mem", {mem.exists(a), bus_val(a)}, {1'b1, wd});
  endtask
  task automatic release_cmd(input int hold);
    int w0, r0;
    w0 = n_wr;
    r0 = n_rd;
    repeat (hold) @(posedge clk);
    check("no_rearm", (n_wr - w0) + (n_rd - r0), 0);
    @(posedge clk);
    #2;
    ctrl_addr = {14'($urandom), 2'b00, 16'($urandom)};
    @(posedge clk);
  endtask
  task automatic reset_check(input string tag);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_flags"}, {busy, done, err_timeout, err_illegal}, 0);
    check({tag, "_txn_cnt"}, txn_cnt, 0);
    check({tag, "_avm_rw"}, {avm.read, avm.write}, 0);
    check({tag, "_avm_addr_data"}, {avm.address, avm.writedata}, 0);
  endtask
  initial begin
    int k, r0;
    ctrl_addr = '0;
    wr_data   = '0;
    #1 rst = 1'b1;
    #2 reset_check("init");
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    wr_hi = 0;
    do_txn(32'h0001_0123, 32'hCAFE_F00D, 2, 0, k);
    check("wr_hold_cycles", wr_hi, 3);
    check("wr_addr", last_addr, 16'h0123);
    check("wr_wdata", last_wdata, 32'hCAFE_F00D);
    release_cmd(10);
    mem[16'h0040]     = 32'h1234_5678;
    exp_mem[16'h0040] = 32'h1234_5678;
    lat = 2;
    do_txn(32'h0002_0040, $urandom, 0, 0, k);
    release_cmd(3);
    do_txn(32'h0003_0010, $urandom, 0, 0, k);
    check("illegal_latency", k, 2);
    release_cmd(2);
    lat = 0;
    do_txn(32'h0001_0007, $urandom, 0, 0, k);
    check("wr_latency", k, 3);
    release_cmd(0);
    do_txn(32'h0002_0007, $urandom, 0, 0, k);
    check("rd_latency", k, 4);
    release_cmd(0);
    r0 = n_rd;
    do_txn(32'h0002_0123, $urandom, 0, 0, k);
    release_cmd(20);
    do_txn(32'h0002_0123, $urandom, 0, 0, k);
    check("rearm_reads", n_rd - r0, 2);
    release_cmd(1);
`ifdef ETH_CSR_TIMEOUT_EN
    stuck = 1;
    rd_hi = 0;
    do_txn(32'h0002_0055, $urandom, 0, 1, k);
    check("tmo_read_hi", rd_hi, 16);
    stuck = 0;
    release_cmd(2);
`endif
    lat = 8;
    @(posedge clk);
    #2 ctrl_addr = 32'h0002_0040;
    repeat (3) @(posedge clk);
    #3 check("mid_read_accepted", {avm.read, busy}, 2'b01);
    rst = 1'b1;
    #1 reset_check("mid");
    ctrl_addr = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    exp_txn = '0;
    exp_rd  = '0;
    repeat (15) @(posedge clk);
    #1 check("late_rvalid_rd_data", rd_data, 0);
    check("late_rvalid_flags", {busy, done, txn_cnt}, 0);
    rnd_stall = 1;
    for (int t = 0; t < 40; t++) begin
      int          ty;
      logic [1:0]  c;
      ty  = $urandom_range(0, 5);
      c   = ty < 3 ? 2'b01 : ty < 5 ? 2'b10 : 2'b11;
      lat = $urandom_range(0, 3);
      do_txn({14'($urandom), c, 16'($urandom_range(0, 7))}, $urandom, $urandom_range(0, 2), 0, k);
      check("rnd_latency_min", k >= 2, 1);
      release_cmd($urandom_range(0, 5));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
